// File: rtl/next_pc_ctrl.sv
// Next-PC control FSM for a multicycle fetch/execute core: sequences instruction
// fetch, waits on data memory for loads/stores, and emits a one-cycle PC advance.
module next_pc_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] instr,
    input  logic        dhit,
    input  logic [31:0] rdat1,
    input  logic        branch_eq,
    output logic        iREN,
    output logic [1:0]  PCSrc,
    output logic [15:0] imm16,
    output logic [25:0] j_addr26,
    output logic [31:0] jr,
    output logic        pc_next,
    output logic        halt,
    output logic [31:0] instr_cnt
);

    typedef enum logic [2:0] {IDLE, FETCH, MEMWAIT, UPDATE, HALT} state_t;
    typedef enum logic [1:0] {PC4 = 2'd0, BR = 2'd1, JMP = 2'd2, JR = 2'd3} pcsrc_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_t      state, next_state;
    pcsrc_t      pcsrc_dec, pcsrc_q;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        capture;

    assign opcode  = instr[31:26];
    assign funct   = instr[5:0];
    assign capture = (state == FETCH) && ihit;
    assign iREN    = (state == FETCH);
    assign PCSrc   = pcsrc_q;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        pcsrc_dec  = PC4;

        unique case (opcode)
            OP_J, OP_JAL: pcsrc_dec = JMP;
            OP_BEQ:       if (branch_eq)      pcsrc_dec = BR;
            OP_BNE:       if (!branch_eq)     pcsrc_dec = BR;
            OP_RTYPE:     if (funct == FN_JR) pcsrc_dec = JR;
            default:      pcsrc_dec = PC4;
        endcase

        case (state)
            IDLE:    next_state = FETCH;
            FETCH: begin
                if (ihit) begin
                    if (opcode == OP_HALT)                        next_state = HALT;
                    else if (opcode == OP_LW || opcode == OP_SW)  next_state = MEMWAIT;
                    else                                          next_state = UPDATE;
                end
            end
            MEMWAIT: if (dhit) next_state = UPDATE;
            UPDATE:  next_state = FETCH;
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs are computed from next_state so they line up with the state they describe.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            pcsrc_q   <= PC4;
            imm16     <= '0;
            j_addr26  <= '0;
            jr        <= '0;
            pc_next   <= 1'b0;
            halt      <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state   <= next_state;
            pc_next <= (next_state == UPDATE);
            if (next_state == UPDATE) instr_cnt <= instr_cnt + 32'd1;
            if (next_state == HALT)   halt      <= 1'b1;
            if (capture) begin
                pcsrc_q  <= pcsrc_dec;
                imm16    <= instr[15:0];
                j_addr26 <= instr[25:0];
                jr       <= rdat1;
            end
        end
    end

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Self-checking bench for next_pc_ctrl: expected retire results are queued at
// fetch time and compared when the pc_next pulse appears.
module tb_next_pc_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit = 1'b0;
    logic [31:0] instr = '0;
    logic        dhit = 1'b0;
    logic [31:0] rdat1 = '0;
    logic        branch_eq = 1'b0;
    logic        iREN;
    logic [1:0]  PCSrc;
    logic [15:0] imm16;
    logic [25:0] j_addr26;
    logic [31:0] jr;
    logic        pc_next;
    logic        halt;
    logic [31:0] instr_cnt;

    typedef struct {
        string       name;
        logic [1:0]  pcsrc;
        logic [15:0] imm;
        logic [25:0] jaddr;
        logic [31:0] jr;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = '0;

    next_pc_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .instr(instr), .dhit(dhit),
        .rdat1(rdat1), .branch_eq(branch_eq), .iREN(iREN), .PCSrc(PCSrc),
        .imm16(imm16), .j_addr26(j_addr26), .jr(jr), .pc_next(pc_next),
        .halt(halt), .instr_cnt(instr_cnt)
    );

    always #5 CLK = ~CLK;

    // Wait for FETCH, present one instruction for one cycle, queue its expected retire values.
    task automatic issue(input string name, input logic [31:0] ins, input logic [31:0] rs,
                         input logic beq, input logic [1:0] exp_src, input logic push);
        exp_t e;
        int   n = 0;
        @(negedge CLK);
        while (iREN !== 1'b1 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (iREN !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait_iren: iREN=%b expected 1 within 10 cycles", name, iREN);
        end
        ihit = 1'b1; instr = ins; rdat1 = rs; branch_eq = beq;
        if (push) begin
            e.name = name; e.pcsrc = exp_src; e.imm = ins[15:0];
            e.jaddr = ins[25:0]; e.jr = rs;
            sb_q.push_back(e);
        end
        @(negedge CLK);
        ihit = 1'b0;
    endtask

    // Wait (bounded) for a pc_next pulse, then pop and compare against the oldest queued entry.
    task automatic scoreboard_pop(input int budget);
        exp_t e;
        int   n = 0;
        while (pc_next !== 1'b1 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (pc_next !== 1'b1 || sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_pulse: pc_next=%b queue=%0d, expected pulse with pending entry",
                     pc_next, sb_q.size());
            return;
        end
        e = sb_q.pop_front();
        exp_cnt = exp_cnt + 32'd1;
        checks++;
        if (PCSrc !== e.pcsrc || imm16 !== e.imm || j_addr26 !== e.jaddr || jr !== e.jr) begin
            errors++;
            $display("FAIL %s_fields: PCSrc=%0d imm16=%h j_addr26=%h jr=%h expected %0d %h %h %h",
                     e.name, PCSrc, imm16, j_addr26, jr, e.pcsrc, e.imm, e.jaddr, e.jr);
        end
        @(negedge CLK);
        checks++;
        if (pc_next !== 1'b0 || instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s_after: pc_next=%b instr_cnt=%0d expected 0 and %0d",
                     e.name, pc_next, instr_cnt, exp_cnt);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (iREN !== 1'b0 || PCSrc !== 2'd0 || imm16 !== '0 || j_addr26 !== '0 || jr !== '0 ||
            pc_next !== 1'b0 || halt !== 1'b0 || instr_cnt !== '0) begin
            errors++;
            $display("FAIL %s: iREN=%b PCSrc=%0d imm16=%h j=%h jr=%h pc_next=%b halt=%b cnt=%0d expected all 0",
                     name, iREN, PCSrc, imm16, j_addr26, jr, pc_next, halt, instr_cnt);
        end
    endtask

    // Release reset just after an edge and confirm one IDLE cycle before FETCH.
    task automatic release_reset(input string name);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (iREN !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: iREN=%b expected 0", name, iREN);
        end
        @(negedge CLK);
        checks++;
        if (iREN !== 1'b1) begin
            errors++;
            $display("FAIL %s_fetch: iREN=%b expected 1", name, iREN);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_all_zero("reset_hold");
        release_reset("reset");
    endtask

    task automatic test_alu();
        issue("addi", 32'h20010005, 32'h0, 1'b0, 2'd0, 1'b1);
        checks++;
        if (pc_next !== 1'b1) begin
            errors++;
            $display("FAIL addi_latency: pc_next=%b expected 1 one cycle after ihit", pc_next);
        end
        scoreboard_pop(0);
    endtask

    task automatic test_branch();
        issue("beq_taken", 32'h1022FFFE, 32'h0, 1'b1, 2'd1, 1'b1);
        scoreboard_pop(2);
        issue("beq_not", 32'h1022FFFE, 32'h0, 1'b0, 2'd0, 1'b1);
        scoreboard_pop(2);
        issue("bne_taken", 32'h14220003, 32'h0, 1'b0, 2'd1, 1'b1);
        scoreboard_pop(2);
    endtask

    task automatic test_jump();
        issue("j", 32'h08000040, 32'h0, 1'b0, 2'd2, 1'b1);
        scoreboard_pop(2);
        issue("jr", 32'h03E00008, 32'h00000100, 1'b0, 2'd3, 1'b1);
        scoreboard_pop(2);
    endtask

    // ihit held into UPDATE with a different instruction must not be captured.
    task automatic test_back_to_back();
        issue("addi_b2b", 32'h20010005, 32'h0, 1'b0, 2'd0, 1'b1);
        ihit = 1'b1; instr = 32'h08000777; rdat1 = 32'h12345678;
        scoreboard_pop(0);
        ihit = 1'b0;
    endtask

    task automatic test_load();
        issue("lw", 32'h8C220000, 32'h0000ABCD, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (iREN !== 1'b0 || pc_next !== 1'b0) begin
                errors++;
                $display("FAIL lw_wait%0d: iREN=%b pc_next=%b expected 0 0", i, iREN, pc_next);
            end
            @(negedge CLK);
        end
        dhit = 1'b1;
        @(negedge CLK);
        dhit = 1'b0;
        checks++;
        if (pc_next !== 1'b1) begin
            errors++;
            $display("FAIL lw_dhit_latency: pc_next=%b expected 1 one cycle after dhit", pc_next);
        end
        scoreboard_pop(0);
        dhit = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            checks++;
            if (pc_next !== 1'b0 || iREN !== 1'b1) begin
                errors++;
                $display("FAIL stray_dhit: pc_next=%b iREN=%b expected 0 1", pc_next, iREN);
            end
        end
        dhit = 1'b0;
    endtask

    task automatic test_halt();
        issue("halt", 32'hFFFFFFFF, 32'h0, 1'b0, 2'd0, 1'b0);
        checks++;
        if (halt !== 1'b1 || pc_next !== 1'b0 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter: halt=%b pc_next=%b iREN=%b expected 1 0 0", halt, pc_next, iREN);
        end
        ihit = 1'b1; dhit = 1'b1; instr = 32'h20010005;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            checks++;
            if (pc_next !== 1'b0 || iREN !== 1'b0 || halt !== 1'b1) begin
                errors++;
                $display("FAIL halt_hold%0d: pc_next=%b iREN=%b halt=%b expected 0 0 1",
                         i, pc_next, iREN, halt);
            end
        end
        ihit = 1'b0; dhit = 1'b0;
        checks++;
        if (instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL halt_cnt: instr_cnt=%0d expected %0d", instr_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_midop();
        RST = 1'b1;
        release_reset("halt_exit");
        sb_q.delete();
        exp_cnt = '0;
        issue("alu_pre", 32'h20010005, 32'h0, 1'b0, 2'd0, 1'b1);
        scoreboard_pop(0);
        issue("lw_rst", 32'h8C220004, 32'hDEADBEEF, 1'b0, 2'd0, 1'b1);
        checks++;
        if (iREN !== 1'b0 || jr !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL memwait_pre: iREN=%b jr=%h expected 0 deadbeef", iREN, jr);
        end
        #1 RST = 1'b1;
        #1 check_all_zero("async_reset");
        sb_q.delete();
        exp_cnt = '0;
        release_reset("midop");
        check_all_zero_but_iren();
        issue("alu_post", 32'h20010005, 32'h0, 1'b0, 2'd0, 1'b1);
        scoreboard_pop(0);
    endtask

    task automatic check_all_zero_but_iren();
        checks++;
        if (instr_cnt !== '0 || pc_next !== 1'b0 || halt !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: instr_cnt=%0d pc_next=%b halt=%b expected 0 0 0",
                     instr_cnt, pc_next, halt);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_jump();
        test_back_to_back();
        test_load();
        test_halt();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/next_pc_ctrl.md
NEXT_PC_CTRL -- requirements
Module: next_pc_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL expose the following ports:
  CLK         in   1   clock, rising edge
  RST         in   1   asynchronous active-high reset
  ihit        in   1   instruction memory returned instr this cycle
  instr       in   32  fetched instruction (word_t)
  dhit        in   1   data memory completed load/store this cycle
  rdat1       in   32  register rs value (word_t), target source for JR
  branch_eq   in   1   rs==rt compare result for the current instruction
  iREN        out  1   instruction fetch request
  PCSrc       out  2   next-PC select (PCSrc_t): 0 PC4, 1 BR, 2 JMP, 3 JR
  imm16       out  16  branch offset
  j_addr26    out  26  jump target field
  jr          out  32  register jump target (word_t)
  pc_next     out  1   one-cycle PC advance strobe
  halt        out  1   processor halted
  instr_cnt   out  32  retired-instruction count
REQ-003 All outputs except iREN SHALL be driven from registers; iREN SHALL be a decode of the current state only.

Function
REQ-004 FSM states SHALL be IDLE, FETCH, MEMWAIT, UPDATE, HALT.
REQ-005 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-006 iREN SHALL be 1 in FETCH only and 0 in all other states.
REQ-007 In FETCH without ihit, the FSM SHALL stay in FETCH and hold all registered outputs.
REQ-008 On ihit in FETCH, the block SHALL capture imm16=instr[15:0], j_addr26=instr[25:0], jr=rdat1.
REQ-009 PCSrc decode SHALL be captured on ihit as follows:
  op 0x02/0x03 -> JMP
  op 0x04 with branch_eq=1 -> BR
  op 0x05 with branch_eq=0 -> BR
  op 0x00 with funct 0x08 -> JR
  otherwise -> PC4
REQ-010 On ihit with op 0x3F, the FSM SHALL enter HALT, set halt=1, and never assert pc_next.
REQ-011 On ihit with op 0x23 or 0x2B, the FSM SHALL enter MEMWAIT; otherwise it SHALL enter UPDATE.
REQ-012 MEMWAIT SHALL hold until dhit=1, then go to UPDATE; dhit seen in any other state SHALL be ignored.
REQ-013 UPDATE SHALL last exactly one cycle with pc_next=1, then return to FETCH.
REQ-014 pc_next SHALL be 0 in every state other than UPDATE.
  - Latency: ihit -> pc_next is 1 cycle for non-memory instructions.
  - Latency: dhit -> pc_next is 1 cycle for load/store.
REQ-015 PCSrc, imm16, j_addr26 and jr SHALL be stable from the cycle after capture through the UPDATE cycle.
REQ-016 instr_cnt SHALL increment by 1 in each UPDATE cycle and wrap from 0xFFFFFFFF to 0.
REQ-017 A halt instruction SHALL NOT increment instr_cnt.
REQ-018 HALT SHALL be absorbing; only RST exits it.
REQ-019 ihit arriving outside FETCH SHALL be ignored with no capture.

Reset
REQ-020 While RST=1, the FSM SHALL be in IDLE and all outputs SHALL be 0: PCSrc=PC4, imm16=0, j_addr26=0, jr=0, pc_next=0, halt=0, instr_cnt=0, iREN=0.
REQ-021 RST asserted mid-operation (FETCH, MEMWAIT, UPDATE or HALT) SHALL force the reset values immediately, without waiting for a clock edge.
REQ-022 A pending pc_next SHALL be discarded when RST is asserted.

Verification
REQ-023 Release reset; ihit with instr=0x20010005 (addi) -> iREN=1 from the 2nd cycle; pc_next=1 for exactly one cycle after ihit; PCSrc=0; instr_cnt=1.
REQ-024 instr=0x1022FFFE with branch_eq=1 -> PCSrc=1, imm16=0xFFFE, one pc_next pulse; repeat with branch_eq=0 -> PCSrc=0.
REQ-025 instr=0x08000040 -> PCSrc=2, j_addr26=0x0000040; instr=0x03E00008 with rdat1=0x00000100 -> PCSrc=3, jr=0x00000100.
REQ-026 instr=0x8C220000 (lw), then dhit after 3 cycles -> iREN=0 and pc_next=0 while waiting; pc_next one cycle after dhit; a stray dhit in FETCH produces no pulse.
REQ-027 instr=0xFFFFFFFF -> halt=1 one cycle after ihit; pc_next and iREN stay 0 for 20 cycles; instr_cnt unchanged.
REQ-028 RST pulsed during MEMWAIT -> all outputs 0 asynchronously; IDLE for one cycle then FETCH; instr_cnt=0.
